// File: rtl/uart_rx_sink.sv
// uart_rx_sink: 8N1 UART receiver feeding a small first-word-fall-through byte FIFO.
// The serial line is double-flopped before use. Every sample is taken mid-bit,
// counted from the synchronised falling edge of the start bit. A low stop bit
// raises a one-cycle frame error. The receiver then ignores the line until it
// returns high, so a held-low break never looks like a new start bit.
module uart_rx_sink #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       rx_in,
    input  logic       rd_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       frame_err_out,
    output logic       overrun_out
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s_q;

    // Two-flop synchroniser; resets to the idle (high) line level
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            frame_err_q, frame_err_d;
    logic            push;

    // FSM state, counters, shift register and frame-error pulse register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic; push is raised in the stop-sample cycle when the stop bit is high
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A start bit that is high again at mid-bit was only a glitch
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_BREAK: begin
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Byte FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          full;
    logic          pop;
    logic          wr_en;

    assign full  = (count_q == DEPTH_C);
    assign pop   = rd_in && valid_out;
    // When full, a simultaneous pop frees the head slot, which is the slot being written
    assign wr_en = push && (!full || pop);

    // FIFO pointer, occupancy and overrun next-state
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - (AW + 1)'(1);
        end
        if (push && full && !pop) begin
            overrun_d = 1'b1;
        end
    end

    // FIFO control registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // FIFO storage; contents need no reset because the output is gated by occupancy
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign valid_out     = (count_q != '0);
    assign data_out      = valid_out ? mem_q[rd_ptr_q] : 8'h00;
    assign frame_err_out = frame_err_q;
    assign overrun_out   = overrun_q;

endmodule
